// File: rtl/ppwm_pkg.sv
// Shared types and register-map constants for the multi-channel PWM generator.
package ppwm_pkg;

   typedef enum logic {MODE_EDGE = 1'b0, MODE_CENTER = 1'b1} ppwm_mode_e;

   localparam int ADDR_PERIOD       = 0;
   localparam int ADDR_CTRL         = 1;
   localparam int ADDR_DUTY0        = 2;

   localparam int CTRL_MODE_BIT     = 0;
   localparam int CTRL_PRESCALE_LSB = 1;

endpackage

// File: rtl/ppwm_prescaler.sv
// Clock prescaler: emits a one-cycle tick every prescale+1 enabled cycles.
module ppwm_prescaler
   import ppwm_pkg::*;
#(
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] pre_cnt_r;

   assign tick = en && (pre_cnt_r == prescale);

   // Prescale counter, frozen while the timebase is disabled
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre_cnt_r <= '0;
      end else if (tick) begin
         pre_cnt_r <= '0;
      end else if (en) begin
         pre_cnt_r <= pre_cnt_r + PRESCALE_W'(1);
      end
   end

endmodule

// File: rtl/ppwm_multi.sv
// Multi-channel PWM: shared prescaled timebase (edge/center aligned) driving
// CHANNELS compare outputs, with shadow/active configuration registers.
module ppwm_multi
   import ppwm_pkg::*;
#(
   parameter  int WIDTH      = 8,
   parameter  int CHANNELS   = 4,
   parameter  int PRESCALE_W = 4,
   localparam int ADDR_W     = $clog2(CHANNELS + 2)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                cfg_we,
   input  logic [ADDR_W-1:0]   cfg_addr,
   input  logic [WIDTH-1:0]    cfg_wdata,
   output logic [CHANNELS-1:0] pwm_out,
   output logic                period_end,
   output logic [WIDTH-1:0]    cnt
);

   localparam int CTRL_W = PRESCALE_W + 1;

   logic [WIDTH-1:0]      period_sh_r;
   logic [WIDTH-1:0]      period_act_r;
   logic [CTRL_W-1:0]     ctrl_sh_r;
   logic [CTRL_W-1:0]     ctrl_act_r;
   logic [WIDTH-1:0]      duty_sh_r  [CHANNELS];
   logic [WIDTH-1:0]      duty_act_r [CHANNELS];
   logic                  dir_down_r;

   ppwm_mode_e            mode_s;
   logic [PRESCALE_W-1:0] prescale_s;
   logic                  tick_s;
   logic                  boundary_s;
   logic [WIDTH-1:0]      cnt_next_s;
   logic                  dir_down_next_s;
   logic [CHANNELS-1:0]   cmp_s;

   assign mode_s     = ppwm_mode_e'(ctrl_act_r[CTRL_MODE_BIT]);
   assign prescale_s = ctrl_act_r[CTRL_PRESCALE_LSB +: PRESCALE_W];

   ppwm_prescaler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .prescale (prescale_s),
      .tick     (tick_s)
   );

   // Next-count / direction / boundary decision for the active mode
   always_comb begin
      cnt_next_s      = cnt;
      dir_down_next_s = dir_down_r;
      boundary_s      = 1'b0;
      if (!tick_s) begin
         cnt_next_s = cnt;
      end else begin
         case (mode_s)
            MODE_EDGE: begin
               if (cnt >= period_act_r) begin
                  boundary_s = 1'b1;
               end else begin
                  cnt_next_s = cnt + WIDTH'(1);
               end
            end
            MODE_CENTER: begin
               // P=1 turns around at 1 straight into the 1->0 boundary step
               if ((period_act_r == '0) ||
                   ((cnt == WIDTH'(1)) && (dir_down_r || (cnt >= period_act_r)))) begin
                  boundary_s = 1'b1;
               end else if (dir_down_r) begin
                  cnt_next_s = cnt - WIDTH'(1);
               end else if (cnt >= period_act_r) begin
                  cnt_next_s      = cnt - WIDTH'(1);
                  dir_down_next_s = 1'b1;
               end else begin
                  cnt_next_s = cnt + WIDTH'(1);
               end
            end
            default: begin
               boundary_s = 1'b1;
            end
         endcase
         if (boundary_s) begin
            cnt_next_s      = '0;
            dir_down_next_s = 1'b0;
         end else begin
            dir_down_next_s = dir_down_next_s;
         end
      end
   end

   // Timebase state, boundary pulse and period/ctrl double-buffering
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt          <= '0;
         dir_down_r   <= 1'b0;
         period_end   <= 1'b0;
         period_sh_r  <= '1;
         period_act_r <= '1;
         ctrl_sh_r    <= '0;
         ctrl_act_r   <= '0;
      end else begin
         cnt        <= cnt_next_s;
         dir_down_r <= dir_down_next_s;
         period_end <= boundary_s;
         if (boundary_s) begin
            period_act_r <= period_sh_r;
            ctrl_act_r   <= ctrl_sh_r;
         end
         if (cfg_we && (cfg_addr == ADDR_W'(ADDR_PERIOD))) begin
            period_sh_r <= cfg_wdata;
         end
         if (cfg_we && (cfg_addr == ADDR_W'(ADDR_CTRL))) begin
            ctrl_sh_r <= cfg_wdata[CTRL_W-1:0];
         end
      end
   end

   // Per-channel duty shadow/active registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            duty_sh_r[i]  <= '0;
            duty_act_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_we && (cfg_addr == ADDR_W'(ADDR_DUTY0 + i))) begin
               duty_sh_r[i] <= cfg_wdata;
            end
            if (boundary_s) begin
               duty_act_r[i] <= duty_sh_r[i];
            end
         end
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_cmp
      assign cmp_s[g] = (cnt < duty_act_r[g]);
   end

   // Registered compare outputs, held while disabled
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pwm_out <= '0;
      end else if (en) begin
         pwm_out <= cmp_s;
      end
   end

endmodule
